// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for the pipelined add/subtract unit.
//
// Upstream side   : in_valid / in_ready / in_a / in_b / in_sub
// Downstream side : out_valid / out_ready / out_sum / out_carry / out_ovf / out_zero / out_neg
//
// Modports
//   master : the agent that feeds operands and consumes results
//   slave  : the add/subtract unit itself
interface pipelined_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    logic             out_zero;
    logic             out_neg;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero, out_neg
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero, out_neg
    );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined integer add/subtract unit.
//
// The WIDTH-bit carry chain is cut into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Stage k adds chunk k of A and B' (B' = ~B for subtract) using the carry registered
// by stage k-1, then registers its own carry out. Operand chunks not yet consumed
// ride along in a shrinking register so they reach their stage together with the
// carry; finished sum chunks accumulate in a growing register so the full result
// leaves the last stage aligned. Latency is STAGES cycles, throughput one beat per
// cycle. The whole pipeline moves only when the output slot is empty or being taken.
//
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears every stage valid bit
//   s    : pipelined_addsub_if.slave
//          in_valid/in_ready/in_a/in_b/in_sub  operand beat (in_sub=1 -> A-B)
//          out_valid/out_ready                 result handshake
//          out_sum                             result mod 2^WIDTH
//          out_carry                           carry out of MSB (sub: 1 = no borrow)
//          out_ovf                             signed overflow
//          out_zero / out_neg                  out_sum == 0 / out_sum[WIDTH-1]
//          all result fields read 0 while out_valid = 0
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_addsub_if.slave s
);

    localparam int CHUNK_REM = (STAGES < 1) ? 1 : (WIDTH % STAGES);
    localparam int CHUNK     = (STAGES < 1) ? WIDTH : (WIDTH / STAGES);

    if ((STAGES < 1) || (STAGES > WIDTH) || (CHUNK_REM != 0)) begin : g_param_check
        $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d), 1 <= STAGES <= WIDTH",
               WIDTH, STAGES);
    end

    // Advance: the last slot is free or is being drained this cycle. Every register
    // in the pipe shares this enable, so bubbles are kept and order is preserved.
    logic adv;
    logic out_vld;

    assign adv        = ~out_vld | s.out_ready;
    assign s.in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still owed to stages k..STAGES-1
        localparam int IW = WIDTH - k * CHUNK;

        logic [IW-1:0]          a_in;
        logic [IW-1:0]          b_in;
        logic                   cin;
        logic                   vld_in;
        logic [CHUNK:0]         chunk_res;
        logic [(k+1)*CHUNK-1:0] sum_nx;

        logic                   vld_p;
        logic                   cy_p;
        logic [(k+1)*CHUNK-1:0] sum_p;

        if (k == 0) begin : g_src
            assign a_in   = s.in_a;
            assign b_in   = s.in_sub ? ~s.in_b : s.in_b;
            assign cin    = s.in_sub;
            assign vld_in = s.in_valid;
            assign sum_nx = chunk_res[CHUNK-1:0];
        end else begin : g_src
            assign a_in   = g_stage[k-1].g_fwd.a_p;
            assign b_in   = g_stage[k-1].g_fwd.b_p;
            assign cin    = g_stage[k-1].cy_p;
            assign vld_in = g_stage[k-1].vld_p;
            // New chunk goes on top of the already finished lower chunks
            assign sum_nx = {chunk_res[CHUNK-1:0], g_stage[k-1].sum_p};
        end

        // The chunk this stage owns always sits at the bottom of its operand slice
        assign chunk_res = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, cin};

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p <= 1'b0;
            end else if (adv) begin
                vld_p <= vld_in;
            end
        end

        always_ff @(posedge clk) begin
            if (adv) begin
                cy_p  <= chunk_res[CHUNK];
                sum_p <= sum_nx;
            end
        end

        // Upper operand chunks are skewed forward to meet their carry one stage later
        if (k < STAGES - 1) begin : g_fwd
            logic [IW-CHUNK-1:0] a_p;
            logic [IW-CHUNK-1:0] b_p;

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_p <= a_in[IW-1:CHUNK];
                    b_p <= b_in[IW-1:CHUNK];
                end
            end
        end
    end

    // Flags come from the last stage's combinational result, which is the full
    // aligned sum. The carry into the MSB is recovered inside the top chunk from
    // its MSB operand bits and MSB sum bit.
    logic msb_cin;
    logic ovf_nx;
    logic zero_nx;
    logic neg_nx;
    logic ovf_p;
    logic zero_p;
    logic neg_p;

    assign msb_cin = g_stage[STAGES-1].a_in[CHUNK-1]
                   ^ g_stage[STAGES-1].b_in[CHUNK-1]
                   ^ g_stage[STAGES-1].chunk_res[CHUNK-1];
    assign ovf_nx  = msb_cin ^ g_stage[STAGES-1].chunk_res[CHUNK];
    assign zero_nx = (g_stage[STAGES-1].sum_nx == '0);
    assign neg_nx  = g_stage[STAGES-1].sum_nx[WIDTH-1];

    // ---- flag register, aligned with the last stage ----
    always_ff @(posedge clk) begin
        if (adv) begin
            ovf_p  <= ovf_nx;
            zero_p <= zero_nx;
            neg_p  <= neg_nx;
        end
    end

    // Result fields are forced to zero whenever no valid beat is presented, so the
    // data registers themselves need no reset.
    assign out_vld     = g_stage[STAGES-1].vld_p;
    assign s.out_valid = out_vld;
    assign s.out_sum   = out_vld ? g_stage[STAGES-1].sum_p : '0;
    assign s.out_carry = out_vld & g_stage[STAGES-1].cy_p;
    assign s.out_ovf   = out_vld & ovf_p;
    assign s.out_zero  = out_vld & zero_p;
    assign s.out_neg   = out_vld & neg_p;

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
module tb_pipelined_addsub;

    localparam int W    = 32;
    localparam int SW_N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- main DUT (STAGES = 4) ----------------
    pipelined_addsub_if #(.WIDTH(W)) bus ();

    pipelined_addsub #(.WIDTH(W), .STAGES(4)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus.slave)
    );

    logic [W+3:0] obs;
    assign obs = {bus.out_carry, bus.out_ovf, bus.out_zero, bus.out_neg, bus.out_sum};

    // ---------------- sweep DUTs (STAGES = 1, 2, 8, 32) ----------------
    logic         sw_valid;
    logic [W-1:0] sw_a;
    logic [W-1:0] sw_b;
    logic         sw_sub;
    logic         sw_vld [SW_N];
    logic         sw_rdy [SW_N];
    logic [W+3:0] sw_obs [SW_N];

    function automatic int sw_stages(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    for (genvar i = 0; i < SW_N; i++) begin : g_sw
        localparam int ST = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 32;
        pipelined_addsub_if #(.WIDTH(W)) ifc ();
        pipelined_addsub #(.WIDTH(W), .STAGES(ST)) u (
            .clk (clk),
            .rst (rst),
            .s   (ifc.slave)
        );
        assign ifc.in_valid  = sw_valid;
        assign ifc.in_a      = sw_a;
        assign ifc.in_b      = sw_b;
        assign ifc.in_sub    = sw_sub;
        assign ifc.out_ready = 1'b1;
        assign sw_vld[i]     = ifc.out_valid;
        assign sw_rdy[i]     = ifc.in_ready;
        assign sw_obs[i]     = {ifc.out_carry, ifc.out_ovf, ifc.out_zero, ifc.out_neg, ifc.out_sum};
    end

    // ---------------- reference model ----------------
    // Returns {carry, ovf, zero, neg, sum}
    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sub};
        ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], ovf, (full[W-1:0] == '0), full[W-1], full[W-1:0]};
    endfunction

    typedef struct {
        logic [W+3:0] exp;
        int           t;
    } sb_t;

    sb_t sbq[$];

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_sub = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid);
        end
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h required 0", obs);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || obs !== '0) begin
            errors++; $display("FAIL post_reset_idle: got valid=%b out=%h required 0/0", bus.out_valid, obs);
        end
    endtask

    // One isolated beat, result compared with hand-derived constants; flags={carry,ovf,zero,neg}
    task automatic test_single(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, input logic [W-1:0] exp_sum, input logic [3:0] exp_flags);
        int t0;
        int lat;
        bit seen;
        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_in_ready: got %b required 1", name, bus.in_ready);
        end
        t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s_timeout: got no out_valid required one within 20 cycles", name);
        end else begin
            lat = cyc - t0;
            if (lat != 4) begin
                errors++; $display("FAIL %s_latency: got %0d required 4", name, lat);
            end
            checks++;
            if (obs !== {exp_flags, exp_sum}) begin
                errors++; $display("FAIL %s_result: got %h required %h", name, obs, {exp_flags, exp_sum});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_basic();
        test_single("add_basic",  32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 4'b0000);
        test_single("add_carry",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 4'b1010);
        test_single("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b0101);
        test_single("add_chunk",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 4'b0000);
        test_single("sub_neg",    32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 4'b0001);
        test_single("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b1100);
        test_single("sub_zero",   32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 4'b1010);
    endtask

    task automatic test_backpressure();
        int sent;
        int got;
        bit acc_last;
        bit prev_stall;
        logic [W+3:0] prev;
        sb_t e;
        sent = 0; got = 0; acc_last = 0; prev_stall = 0; prev = '0;
        sbq.delete();
        bus.in_valid = 1'b0;
        for (int g = 0; g < 400 && got < 8; g++) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || obs !== prev) begin
                    errors++; $display("FAIL bp_stable: got valid=%b out=%h required 1/%h", bus.out_valid, obs, prev);
                end
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            if (acc_last) bus.in_valid = 1'b0;
            if (!bus.in_valid && sent < 8) begin
                bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sub = 1'($urandom_range(0, 1));
                bus.in_valid = 1'b1;
            end
            #1;
            acc_last = 0;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
                checks++;
                if (bus.in_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_in_ready_stall: got %b required 0", bus.in_ready);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL bp_extra_beat: got out=%h required no output", obs);
                end else begin
                    e = sbq.pop_front();
                    if (obs !== e.exp) begin
                        errors++; $display("FAIL bp_result[%0d]: got %h required %h", got, obs, e.exp);
                    end
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                e.exp = model(bus.in_a, bus.in_b, bus.in_sub);
                e.t   = cyc;
                sbq.push_back(e);
                sent++;
                acc_last = 1;
            end
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
            prev = obs;
        end
        checks++;
        if (got != 8 || sbq.size() != 0) begin
            errors++; $display("FAIL bp_count: got %0d results (%0d pending) required 8 (0)", got, sbq.size());
        end
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        sb_t e;
        sent = 0; got = 0;
        sbq.delete();
        bus.out_ready = 1'b1;
        for (int g = 0; g < 60 && got < 12; g++) begin
            @(negedge clk);
            if (sent < 12) begin
                bus.in_a = $urandom; bus.in_b = $urandom; bus.in_sub = 1'(g & 1);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_beat: got out=%h required no output", obs);
                end else begin
                    e = sbq.pop_front();
                    if (obs !== e.exp || (cyc - e.t) != 4) begin
                        errors++; $display("FAIL b2b_result[%0d]: got %h lat %0d required %h lat 4",
                                           got, obs, cyc - e.t, e.exp);
                    end
                end
                got++;
            end
            if (bus.in_valid === 1'b1) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_in_ready: got %b required 1", bus.in_ready);
                end else begin
                    e.exp = model(bus.in_a, bus.in_b, bus.in_sub);
                    e.t   = cyc;
                    sbq.push_back(e);
                    sent++;
                end
            end
        end
        checks++;
        if (got != 12) begin
            errors++; $display("FAIL b2b_count: got %0d required 12", got);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int t0;
        bit seen;
        bit leak;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_a = 32'h0000_0011; bus.in_b = 32'h0000_0022; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_a = 32'h1234_5678; bus.in_b = 32'h0000_0001; bus.in_sub = 1'b1;
        @(negedge clk);
        bus.in_a = 32'hFFFF_0000; bus.in_b = 32'h0001_0000; bus.in_sub = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        leak = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) leak = 1;
        end
        checks++;
        if (leak) begin
            errors++; $display("FAIL flush_no_output: got out_valid=1 required 0 for flushed beats");
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_ready: got %b required 1", bus.in_ready);
        end
        bus.in_a = 32'h0000_1000; bus.in_b = 32'h0000_0234; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.out_valid === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen || (cyc - t0) != 4 || obs !== {4'b0000, 32'h0000_1234}) begin
            errors++; $display("FAIL flush_next_beat: got seen=%0d lat %0d out %h required 1 lat 4 out %h",
                               seen, cyc - t0, obs, {4'b0000, 32'h0000_1234});
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [W+3:0] exp;
        int  t0;
        bit  done [SW_N];
        bit  all_done;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            case (n)
                0:       begin sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0001; sw_sub = 1'b0; end
                1:       begin sw_a = 32'h8000_0000; sw_b = 32'h0000_0001; sw_sub = 1'b1; end
                default: begin sw_a = $urandom; sw_b = $urandom; sw_sub = 1'($urandom_range(0, 1)); end
            endcase
            sw_valid = 1'b1;
            exp = model(sw_a, sw_b, sw_sub);
            t0 = cyc;
            #1;
            for (int i = 0; i < SW_N; i++) begin
                checks++;
                if (sw_rdy[i] !== 1'b1) begin
                    errors++; $display("FAIL sweep_in_ready_s%0d: got %b required 1", sw_stages(i), sw_rdy[i]);
                end
                done[i] = 0;
            end
            @(negedge clk);
            sw_valid = 1'b0;
            all_done = 0;
            for (int c = 0; c < 40 && !all_done; c++) begin
                all_done = 1;
                for (int i = 0; i < SW_N; i++) begin
                    if (!done[i] && sw_vld[i] === 1'b1) begin
                        done[i] = 1;
                        checks++;
                        if ((cyc - t0) != sw_stages(i) || sw_obs[i] !== exp) begin
                            errors++; $display("FAIL sweep_s%0d_op%0d: got lat %0d out %h required lat %0d out %h",
                                               sw_stages(i), n, cyc - t0, sw_obs[i], sw_stages(i), exp);
                        end
                    end
                    if (!done[i]) all_done = 0;
                end
                if (!all_done) @(negedge clk);
            end
            for (int i = 0; i < SW_N; i++) begin
                if (!done[i]) begin
                    checks++; errors++;
                    $display("FAIL sweep_s%0d_timeout: got no out_valid required one", sw_stages(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t required completion", $time);
        $fatal(1);
    end

endmodule
